pll_lock_monitor: RTL and testbench

PLL_LOCK_MONITOR -- requirements
Module: pll_lock_monitor

---
 rtl/pll_mon_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_lock_monitor.sv | 127 ++++++++++++
 tb/tb_pll_lock_monitor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_mon_pkg.sv
// Shared definitions for the PLL lock monitor: FSM state type, default
// parameter values and a counter-width helper.
package pll_mon_pkg;

  typedef enum logic [1:0] {
    RST_PLL   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } pll_state_e;

  localparam int unsigned DEF_LOCK_STABLE_CYC  = 1024;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 1000000;
  localparam int unsigned DEF_PLL_RST_CYC      = 16;
  localparam int unsigned DEF_LOSS_CNT_W       = 8;

  // A counter running 0..n-1 needs $clog2(n) bits; keep at least one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into i_clk.
// Both stages clear on the synchronous reset.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_monitor.sv
// Sequences PLL reset, waits for a stable lock before releasing downstream
// logic, and re-resets the PLL on timeout or loss of lock while keeping stats.
module pll_lock_monitor
  import pll_mon_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int unsigned PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int unsigned LOSS_CNT_W       = DEF_LOSS_CNT_W
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  pll_locked,
  input  logic                  clr_stat,
  output logic                  pll_rst,
  output logic                  user_rst_n,
  output logic                  clk_ok,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
  output logic                  timeout_flag,
  output pll_state_e            dbg_state
);

  localparam int unsigned RST_W  = cnt_w(PLL_RST_CYC);
  localparam int unsigned TO_W   = cnt_w(LOCK_TIMEOUT_CYC);
  localparam int unsigned STAB_W = cnt_w(LOCK_STABLE_CYC);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(PLL_RST_CYC - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(LOCK_STABLE_CYC - 1);

  logic              w_locked_s;
  pll_state_e        r_state;
  pll_state_e        w_next_state;
  logic [RST_W-1:0]  r_rst_cnt;
  logic [RST_W-1:0]  w_rst_cnt_nxt;
  logic [TO_W-1:0]   r_to_cnt;
  logic [TO_W-1:0]   w_to_cnt_nxt;
  logic [STAB_W-1:0] r_stab_cnt;
  logic [STAB_W-1:0] w_stab_cnt_nxt;
  logic              w_loss_evt;
  logic              w_timeout_evt;
  logic              w_loss_sat;
  logic [LOSS_CNT_W-1:0] r_loss_cnt;
  logic              r_timeout_flag;

  sync_2ff u_lock_sync (
    .i_clk (sys_clk),
    .i_rst (sys_rst),
    .i_d   (pll_locked),
    .o_q   (w_locked_s)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state    <= RST_PLL;
      r_rst_cnt  <= '0;
      r_to_cnt   <= '0;
      r_stab_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_stab_cnt <= w_stab_cnt_nxt;
    end
  end

  // Each counter only advances while its state is held; any state change
  // leaves every counter at zero, so each phase starts counting fresh.
  always_comb begin
    w_next_state   = r_state;
    w_rst_cnt_nxt  = '0;
    w_to_cnt_nxt   = '0;
    w_stab_cnt_nxt = '0;
    w_loss_evt     = 1'b0;
    w_timeout_evt  = 1'b0;
    case (r_state)
      RST_PLL: begin
        if (r_rst_cnt == RST_LAST) w_next_state = WAIT_LOCK;
        else                       w_rst_cnt_nxt = r_rst_cnt + 1'b1;
      end
      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_next_state = STABLE;
        end else if (r_to_cnt == TO_LAST) begin
          w_next_state  = RST_PLL;
          w_timeout_evt = 1'b1;
        end else begin
          w_to_cnt_nxt = r_to_cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!w_locked_s)                w_next_state   = WAIT_LOCK;
        else if (r_stab_cnt == STAB_LAST) w_next_state = RUN;
        else                            w_stab_cnt_nxt = r_stab_cnt + 1'b1;
      end
      RUN: begin
        if (!w_locked_s) begin
          w_next_state = RST_PLL;
          w_loss_evt   = 1'b1;
        end
      end
      default: w_next_state = RST_PLL;
    endcase
  end

  assign w_loss_sat = &r_loss_cnt;

  // A clear coincident with an event keeps that event in the fresh count.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_loss_cnt     <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      if (clr_stat)                      r_loss_cnt <= LOSS_CNT_W'(w_loss_evt);
      else if (w_loss_evt && !w_loss_sat) r_loss_cnt <= r_loss_cnt + 1'b1;
      r_timeout_flag <= clr_stat ? w_timeout_evt : (r_timeout_flag | w_timeout_evt);
    end
  end

  assign pll_rst       = (r_state == RST_PLL);
  assign user_rst_n    = (r_state == RUN);
  assign clk_ok        = (r_state == RUN);
  assign lock_loss_cnt = r_loss_cnt;
  assign timeout_flag  = r_timeout_flag;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Bench for pll_lock_monitor: directed scenarios with literal expectations
// plus randomized lock/clear/reset traffic checked against a phase-timing model.
module tb_pll_lock_monitor;
  import pll_mon_pkg::*;

  localparam int STAB = 8;
  localparam int TOUT = 100;
  localparam int RSTC = 4;
  localparam int LW   = 4;
  localparam int LMAX = (1 << LW) - 1;

  localparam int M_RESETTING = 0;
  localparam int M_WAITING   = 1;
  localparam int M_SETTLING  = 2;
  localparam int M_RUNNING   = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          pll_locked = 1'b0;
  logic          clr_stat = 1'b0;
  logic          pll_rst;
  logic          user_rst_n;
  logic          clk_ok;
  logic [LW-1:0] lock_loss_cnt;
  logic          timeout_flag;
  pll_state_e    dbg_state;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  pll_lock_monitor #(
    .LOCK_STABLE_CYC  (STAB),
    .LOCK_TIMEOUT_CYC (TOUT),
    .PLL_RST_CYC      (RSTC),
    .LOSS_CNT_W       (LW)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .pll_locked    (pll_locked),
    .clr_stat      (clr_stat),
    .pll_rst       (pll_rst),
    .user_rst_n    (user_rst_n),
    .clk_ok        (clk_ok),
    .lock_loss_cnt (lock_loss_cnt),
    .timeout_flag  (timeout_flag),
    .dbg_state     (dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: each phase lasts a number of cycles decided from the elapsed
  // time since it began; lock is seen two samples late.
  bit m_valid = 1'b0;
  int cyc = 0;
  int m_mode, m_tin, m_s1, m_s2, m_loss, m_tflag;
  int m_ls, m_age, m_loss_ev, m_to_ev;

  function automatic void m_enter(input int mode);
    m_mode = mode;
    m_tin  = cyc + 1;
  endfunction

  always @(posedge sys_clk) begin
    cyc++;
    if (sys_rst) begin
      m_valid = 1'b1;
      m_enter(M_RESETTING);
      m_s1 = 0; m_s2 = 0; m_loss = 0; m_tflag = 0;
    end else if (m_valid) begin
      m_ls = m_s2;
      m_age = cyc - m_tin + 1;
      m_loss_ev = 0;
      m_to_ev = 0;
      case (m_mode)
        M_RESETTING: if (m_age >= RSTC) m_enter(M_WAITING);
        M_WAITING: begin
          if (m_ls == 1) m_enter(M_SETTLING);
          else if (m_age >= TOUT) begin m_enter(M_RESETTING); m_to_ev = 1; end
        end
        M_SETTLING: begin
          if (m_ls == 0) m_enter(M_WAITING);
          else if (m_age >= STAB) m_enter(M_RUNNING);
        end
        default: if (m_ls == 0) begin m_enter(M_RESETTING); m_loss_ev = 1; end
      endcase
      if (clr_stat) m_loss = m_loss_ev;
      else m_loss = (m_loss + m_loss_ev > LMAX) ? LMAX : m_loss + m_loss_ev;
      m_tflag = clr_stat ? m_to_ev : (m_tflag | m_to_ev);
      m_s2 = m_s1;
      m_s1 = int'(pll_locked);
    end
  end

  // scoreboard: every cycle once the model has seen a reset edge
  always @(negedge sys_clk) begin
    if (m_valid) begin
      chk("m_pll_rst", pll_rst, m_mode == M_RESETTING);
      chk("m_user_rst_n", user_rst_n, m_mode == M_RUNNING);
      chk("m_clk_ok", clk_ok, m_mode == M_RUNNING);
      chk("m_loss_cnt", lock_loss_cnt, m_loss);
      chk("m_timeout_flag", timeout_flag, m_tflag);
    end
  end

  // driver tasks
  task automatic wait_run(input int limit, output int lat);
    int c;
    c = 0;
    do begin
      @(negedge sys_clk);
      c++;
    end while (user_rst_n !== 1'b1 && c < limit);
    chk("run_reached", user_rst_n, 1);
    lat = c - 1;
  endtask

  task automatic wait_rst_low(input int limit);
    int c;
    c = 0;
    while (pll_rst === 1'b1 && c < limit) begin
      @(negedge sys_clk);
      c++;
    end
    chk("pll_rst_dropped", pll_rst, 0);
  endtask

  int n, lat, runs, prev, hi_len, hold;
  int rises[$];
  int widths[$];

  initial begin
    // reset state
    repeat (3) @(negedge sys_clk);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_user_rst_n", user_rst_n, 0);
    chk("rst_clk_ok", clk_ok, 0);
    chk("rst_loss", lock_loss_cnt, 0);
    chk("rst_tflag", timeout_flag, 0);
    chk("rst_state", dbg_state, RST_PLL);

    // normal lock
    sys_rst = 1'b0;
    n = 0;
    while (pll_rst === 1'b1 && n < 50) begin
      n++;
      @(negedge sys_clk);
    end
    chk("rst_pulse_len", n, RSTC);
    repeat (5) @(negedge sys_clk);
    pll_locked = 1'b1;
    wait_run(200, lat);
    chk("lock_latency_in_range", (lat >= 9 && lat <= 11), 1);
    chk("lock_clk_ok", clk_ok, 1);

    // glitch during settling
    sys_rst = 1'b1;
    pll_locked = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    wait_rst_low(50);
    repeat (3) @(negedge sys_clk);
    runs = 0;
    pll_locked = 1'b1;
    repeat (5) begin @(negedge sys_clk); runs += int'(clk_ok); end
    pll_locked = 1'b0;
    @(negedge sys_clk);
    runs += int'(clk_ok);
    pll_locked = 1'b1;
    wait_run(200, lat);
    chk("glitch_no_early_run", runs, 0);
    chk("glitch_latency", lat, 10);
    chk("glitch_loss", lock_loss_cnt, 0);

    // timeout with lock held low
    sys_rst = 1'b1;
    pll_locked = 1'b0;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    prev = 1;
    hi_len = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge sys_clk);
      if (pll_rst && !prev) begin rises.push_back(i); hi_len = 0; end
      if (pll_rst) hi_len++;
      if (!pll_rst && prev && rises.size() > 0) widths.push_back(hi_len);
      prev = int'(pll_rst);
    end
    chk("timeout_rises", rises.size(), 3);
    chk("timeout_period", rises[1] - rises[0], TOUT + RSTC);
    chk("timeout_width0", widths[0], RSTC);
    chk("timeout_width1", widths[1], RSTC);
    chk("timeout_flag_set", timeout_flag, 1);
    clr_stat = 1'b1;
    @(negedge sys_clk);
    clr_stat = 1'b0;
    chk("timeout_flag_clr", timeout_flag, 0);

    // repeated lock loss while running
    pll_locked = 1'b1;
    wait_run(300, lat);
    for (int k = 0; k < 20; k++) begin
      pll_locked = 1'b0;
      n = 0;
      do begin
        @(negedge sys_clk);
        n++;
      end while (user_rst_n !== 1'b0 && n < 20);
      chk("loss_release_within_3", n <= 3, 1);
      pll_locked = 1'b1;
      wait_run(300, lat);
    end
    chk("loss_saturated", lock_loss_cnt, LMAX);

    // clear on the same edge as a loss
    pll_locked = 1'b0;
    @(negedge sys_clk);
    @(negedge sys_clk);
    clr_stat = 1'b1;
    @(negedge sys_clk);
    clr_stat = 1'b0;
    chk("coincide_loss", lock_loss_cnt, 1);
    chk("coincide_pll_rst", pll_rst, 1);

    // reset while running
    pll_locked = 1'b1;
    wait_run(300, lat);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("midrst_pll_rst", pll_rst, 1);
    chk("midrst_user_rst_n", user_rst_n, 0);
    chk("midrst_clk_ok", clk_ok, 0);
    chk("midrst_loss", lock_loss_cnt, 0);
    chk("midrst_tflag", timeout_flag, 0);
    sys_rst = 1'b0;

    // random traffic
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 9) < 7);
        hold = ($urandom_range(0, 19) == 0) ? $urandom_range(100, 160) : $urandom_range(1, 30);
      end
      hold--;
      clr_stat = ($urandom_range(0, 15) == 0);
      sys_rst = ($urandom_range(0, 499) == 0);
      @(negedge sys_clk);
    end
    clr_stat = 1'b0;
    sys_rst = 1'b0;
    repeat (5) @(negedge sys_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
